imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
Registered, handshaked immediate generator for the decode stage; successor to the combinational 32-bit generator. Takes instruction bits [31:7] plus an immediate-select code and returns the XLEN-wide immediate one cycle later. A 2-entry skid buffer provides backpressure tolerance, and flush support lets the block sit between fetch/decode and issue without stalling on downstream ready. It adds XLEN=64 support, CSR zimm and shift-amount formats, a sideband tag passthrough, and an illegal-shamt flag.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 8, width of sideband tag (PC index / ROB id) carried alongside the immediate.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous flush; discards all held entries
in_valid  input  1  upstream entry valid
in_ready  output  1  block can accept an entry this cycle
in_instr  input  25  instruction bits [31:7]; in_instr[k] = instr[k+7]
in_sel  input  3  imm_sel_e format code
in_tag  input  TAG_W  sideband tag
out_valid  output  1  output entry valid
out_ready  input  1  downstream accepts the output entry
out_imm  output  XLEN  generated immediate
out_tag  output  TAG_W  tag of the output entry
out_illegal  output  1  entry had an illegal shift amount

Behaviour:
- Format codes (instr bit positions):
  - 0 S: sext({instr[31:25], instr[11:7]})
  - 1 I: sext(instr[31:20])
  - 2 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - 3 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - 4 U: sext({instr[31:12], 12'b0}); for XLEN=64, bits 63:32 replicate instr[31]
  - 5 Z: zext(instr[19:15]), used by CSR*I
  - 6 SH: zext(instr[25:20]) if XLEN=64, zext(instr[24:20]) if XLEN=32
  - 7 NONE: 0
- sext/zext always extend to the full XLEN.
- out_illegal = 1 only when sel=SH, XLEN=32 and instr[25]=1. out_imm is still the 5-bit zext in that case. out_illegal is 0 for all other codes.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready; output transfer occurs when out_valid & out_ready.
  - out_imm, out_tag and out_illegal are stable while out_valid=1 and out_ready=0.
- Latency: an entry accepted in cycle N appears on the outputs in cycle N+1 if the output register was empty or draining in cycle N.
- State machine, tracked by occupancy:
  - EMPTY: out_valid=0, in_ready=1.
    - accept -> ONE.
  - ONE: output register holds an entry, skid buffer empty, in_ready=1.
    - accept with no drain -> TWO (new entry goes to skid).
    - accept with drain -> ONE (new entry loads output register directly).
    - drain with no accept -> EMPTY.
  - TWO: both full, in_ready=0.
    - drain -> ONE (skid moves to output register).
    - no drain -> hold.
- in_ready is derived from registered state only (~skid_valid); no combinational path from out_ready.
- Entries leave in strict FIFO order.
- Flush:
  - Next state is EMPTY regardless of the other inputs.
  - An input presented in the flush cycle is dropped, even if in_ready=1.
  - An output transfer in the flush cycle still counts downstream.
  - out_valid=0 the following cycle.
- Reset (asynchronous, rst_n=0): state EMPTY, out_valid=0, out_imm=0, out_tag=0, out_illegal=0, skid contents 0, in_ready=1. Reset mid-transfer discards all entries.
- Data registers load only on accept/shift. No X-propagation onto out_* while out_valid=0; outputs hold their last value.

Decomposition:
- Package imm_pkg:
  - imm_sel_e enum (3 bits; values 0..7 as listed above; codes 0-4 numbered as in the existing generator so decode tables carry over).
  - Localparams for field positions.
- Sub-module imm_decode: purely combinational (in_instr, in_sel) -> (imm, illegal), parametrised by XLEN, instantiated once on the input side.
- imm_gen_pipe holds only the skid/output registers and control.

Test Plan:
- XLEN=32, addi x1,x0,-1 (instr 0xFFF00093, in_instr=0x1FFE001, sel=I), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
- XLEN=64, lui x1,0x80000 (0x800000B7, sel=U) -> out_imm=0xFFFFFFFF80000000. beq offset -2 (0xFE000FE3, sel=B) -> 0xFFFFFFFFFFFFFFFE.
- XLEN=32, slli x1,x1,32 (0x02009093, sel=SH) -> out_imm=0x0, out_illegal=1. Same on XLEN=64 -> out_imm=0x20, out_illegal=0.
- Backpressure: out_ready=0, push tags 1,2,3 back-to-back:
  - tags 1 and 2 are accepted; in_ready=0 from the cycle after 2 is accepted; tag 3 is held.
  - raise out_ready -> outputs 1,2,3 in order, no loss or duplication.
- Flush in TWO state with in_valid=1 carrying tag 9 -> next cycle out_valid=0, in_ready=1; tag 9 never appears.
- Assert rst_n=0 asynchronously mid-stream in TWO state -> out_valid, out_imm, out_tag and out_illegal go to 0 immediately (no clock edge needed); in_ready=1 once reset is released.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and instruction field positions for the pipelined immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        SEL_S    = 3'd0,
        SEL_I    = 3'd1,
        SEL_B    = 3'd2,
        SEL_J    = 3'd3,
        SEL_U    = 3'd4,
        SEL_Z    = 3'd5,
        SEL_SH   = 3'd6,
        SEL_NONE = 3'd7
    } imm_sel_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_e;

    localparam int INSTR_LSB = 7;
    localparam int SIGN_BIT  = 31;
    localparam int RS1_HI    = 19;
    localparam int RS1_LO    = 15;
    localparam int SHAMT_HI  = 25;
    localparam int SHAMT_LO  = 20;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction from instruction bits [31:7], extended to XLEN.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]     instr_i,
    input  logic [2:0]      sel_i,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    // Indexed by real instruction bit numbers so the format table reads like the ISA manual.
    logic [SIGN_BIT:INSTR_LSB] ins;
    logic [31:0]               v32;
    logic                      sext;

    assign ins = instr_i;

    always_comb begin
        v32       = '0;
        sext      = 1'b1;
        illegal_o = 1'b0;
        case (imm_sel_e'(sel_i))
            SEL_S:  v32 = {{20{ins[SIGN_BIT]}}, ins[31:25], ins[11:7]};
            SEL_I:  v32 = {{20{ins[SIGN_BIT]}}, ins[31:20]};
            SEL_B:  v32 = {{19{ins[SIGN_BIT]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            SEL_J:  v32 = {{11{ins[SIGN_BIT]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            SEL_U:  v32 = {ins[31:12], 12'b0};
            SEL_Z: begin
                sext = 1'b0;
                v32  = {27'b0, ins[RS1_HI:RS1_LO]};
            end
            SEL_SH: begin
                sext = 1'b0;
                if (XLEN == 64) begin
                    v32 = {26'b0, ins[SHAMT_HI:SHAMT_LO]};
                end else begin
                    v32       = {27'b0, ins[SHAMT_HI-1:SHAMT_LO]};
                    illegal_o = ins[SHAMT_HI];
                end
            end
            default: begin
                v32  = '0;
                sext = 1'b0;
            end
        endcase
        imm_o = sext ? XLEN'($signed(v32)) : XLEN'(v32);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer and synchronous flush.
//   state    | meaning
//   ST_EMPTY | no entry held; out_valid=0, in_ready=1
//   ST_ONE   | output register full, skid empty; in_ready=1
//   ST_TWO   | output register and skid full; in_ready=0
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    occ_state_e       state_q;
    logic [XLEN-1:0]  out_imm_q, skid_imm_q;
    logic [TAG_W-1:0] out_tag_q, skid_tag_q;
    logic             out_ill_q, skid_ill_q;
    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;
    logic             accept, drain;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (in_instr),
        .sel_i     (in_sel),
        .imm_o     (dec_imm),
        .illegal_o (dec_ill)
    );

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready & ~flush;
    assign drain     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_imm_q  <= '0;
            out_tag_q  <= '0;
            out_ill_q  <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_ill_q <= 1'b0;
        end else if (flush) begin
            // Data registers keep their last value; only occupancy is cleared.
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_imm_q <= dec_imm;
                        out_tag_q <= in_tag;
                        out_ill_q <= dec_ill;
                        state_q   <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        skid_imm_q <= dec_imm;
                        skid_tag_q <= in_tag;
                        skid_ill_q <= dec_ill;
                        state_q    <= ST_TWO;
                    end else if (accept) begin
                        out_imm_q <= dec_imm;
                        out_tag_q <= in_tag;
                        out_ill_q <= dec_ill;
                    end else if (drain) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        out_imm_q <= skid_imm_q;
                        out_tag_q <= skid_tag_q;
                        out_ill_q <= skid_ill_q;
                        state_q   <= ST_ONE;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign out_imm     = out_imm_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_ill_q;

endmodule
